decoder_nx2n_scan: RTL and testbench

//   Registered, parametrised N-to-2^N one-hot decoder with enable.
//   Two modes:
//   - MANUAL: decodes iA.
//   - SCAN: auto-steps the address every PRESCALE clocks.

---
 rtl/decoder_nx2n_scan.sv | 97 +++++++++
 tb/tb_decoder_nx2n_scan.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/decoder_nx2n_scan.sv
// Registered N-to-2^N one-hot decoder with enable, manual addressing and auto-scan.
// Define DEC_ACTIVE_LOW_EN to drive oD one-cold (idle/reset value all ones).
module decoder_nx2n_scan #(
    parameter int N        = 2,
    parameter int PRESCALE = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iE,
    input  logic              iMode,
    input  logic [N-1:0]      iA,
    output logic [2**N-1:0]   oD,
    output logic [N-1:0]      oSel,
    output logic              oWrap
);

    localparam int W     = 2**N;
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    // Polarity mask XOR-ed onto the one-hot vector; also the reset/idle value.
`ifdef DEC_ACTIVE_LOW_EN
    localparam logic [W-1:0] D_IDLE = {W{1'b1}};
`else
    localparam logic [W-1:0] D_IDLE = {W{1'b0}};
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MANUAL = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     d_q, d_d;
    logic [N-1:0]     sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic [W-1:0]     hot;
    logic [CNT_W-1:0] cnt_base;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= IDLE;
            d_q     <= D_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        state_d  = IDLE;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        hot      = '0;
        // A scan entered from manual mode always starts a fresh prescale period.
        cnt_base = (state_q == MANUAL) ? '0 : cnt_q;

        case ({iE, iMode})
            2'b10: begin
                state_d = MANUAL;
                sel_d   = iA;
                cnt_d   = '0;
                hot     = W'(1) << iA;
            end
            2'b11: begin
                state_d = SCAN;
                if (cnt_base == CNT_LAST) begin
                    cnt_d  = '0;
                    sel_d  = sel_q + N'(1);
                    wrap_d = (sel_q == {N{1'b1}});
                end else begin
                    cnt_d  = cnt_base + CNT_W'(1);
                end
                hot = W'(1) << sel_d;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        d_d = hot ^ D_IDLE;
    end

    assign oD    = d_q;
    assign oSel  = sel_q;
    assign oWrap = wrap_q;

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Scoreboard bench: directed vectors push expected outputs; per-DUT monitors compare.
module tb_decoder_nx2n_scan;

    logic       clk;
    logic       rst;
    logic       e1, m1;
    logic [1:0] a1;
    logic [3:0] d1;
    logic [1:0] s1;
    logic       w1;
    logic       e2, m2;
    logic [2:0] a2;
    logic [7:0] d2;
    logic [2:0] s2;
    logic       w2;

    int checks = 0;
    int errors = 0;

    logic [6:0]  q1[$];
    logic [11:0] q2[$];

    decoder_nx2n_scan #(.N(2), .PRESCALE(3)) dut1 (
        .iClk(clk), .iRst(rst), .iE(e1), .iMode(m1), .iA(a1),
        .oD(d1), .oSel(s1), .oWrap(w1)
    );

    decoder_nx2n_scan #(.N(3), .PRESCALE(1)) dut2 (
        .iClk(clk), .iRst(rst), .iE(e2), .iMode(m2), .iA(a2),
        .oD(d2), .oSel(s2), .oWrap(w2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DEC_ACTIVE_LOW_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif

    function automatic logic [3:0] pol4(input logic [3:0] v);
        return POL ? ~v : v;
    endfunction

    function automatic logic [7:0] pol8(input logic [7:0] v);
        return POL ? ~v : v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive DUT1 for the next edge; expected oD given active-high.
    task automatic drv1(input logic e, input logic m, input logic [1:0] a,
                        input logic [3:0] xd, input logic [1:0] xs, input logic xw);
        @(negedge clk);
        rst = 1'b0;
        e1 = e; m1 = m; a1 = a;
        q1.push_back({pol4(xd), xs, xw});
    endtask

    task automatic drv2(input logic e, input logic m, input logic [2:0] a,
                        input logic [7:0] xd, input logic [2:0] xs, input logic xw);
        @(negedge clk);
        rst = 1'b0;
        e2 = e; m2 = m; a2 = a;
        q2.push_back({pol8(xd), xs, xw});
    endtask

    initial begin
        logic [6:0] x;
        forever begin
            @(posedge clk);
            #1;
            if (q1.size() != 0) begin
                x = q1.pop_front();
                checks++;
                if ({d1, s1, w1} !== x) begin
                    errors++;
                    $display("FAIL dut1 t=%0t: oD=%b oSel=%b oWrap=%b expected oD=%b oSel=%b oWrap=%b",
                             $time, d1, s1, w1, x[6:3], x[2:1], x[0]);
                end
            end
        end
    end

    initial begin
        logic [11:0] x;
        forever begin
            @(posedge clk);
            #1;
            if (q2.size() != 0) begin
                x = q2.pop_front();
                checks++;
                if ({d2, s2, w2} !== x) begin
                    errors++;
                    $display("FAIL dut2 t=%0t: oD=%b oSel=%b oWrap=%b expected oD=%b oSel=%b oWrap=%b",
                             $time, d2, s2, w2, x[11:4], x[3:1], x[0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        e1 = 1'b0; m1 = 1'b0; a1 = '0;
        e2 = 1'b0; m2 = 1'b0; a2 = '0;

        // Async reset with no clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_d1",    16'(d1), 16'(pol4(4'b0000)));
        chk("rst_sel1",  16'(s1), 16'd0);
        chk("rst_wrap1", 16'(w1), 16'd0);
        chk("rst_d2",    16'(d2), 16'(pol8(8'h00)));
        chk("rst_sel2",  16'(s2), 16'd0);
        drv1(0, 0, 2'b00, 4'b0000, 2'b00, 0);
        drv1(0, 0, 2'b00, 4'b0000, 2'b00, 0);

        // Manual decode then disable
        drv1(1, 0, 2'b00, 4'b0001, 2'b00, 0);
        drv1(1, 0, 2'b01, 4'b0010, 2'b01, 0);
        drv1(1, 0, 2'b10, 4'b0100, 2'b10, 0);
        drv1(1, 0, 2'b11, 4'b1000, 2'b11, 0);
        drv1(0, 0, 2'b00, 4'b0000, 2'b11, 0);

        // Scan from 00 for 12 clocks
        drv1(1, 0, 2'b00, 4'b0001, 2'b00, 0);
        drv1(1, 1, 2'b00, 4'b0001, 2'b00, 0);
        drv1(1, 1, 2'b00, 4'b0001, 2'b00, 0);
        drv1(1, 1, 2'b00, 4'b0010, 2'b01, 0);
        drv1(1, 1, 2'b00, 4'b0010, 2'b01, 0);
        drv1(1, 1, 2'b00, 4'b0010, 2'b01, 0);
        drv1(1, 1, 2'b00, 4'b0100, 2'b10, 0);
        drv1(1, 1, 2'b00, 4'b0100, 2'b10, 0);
        drv1(1, 1, 2'b00, 4'b0100, 2'b10, 0);
        drv1(1, 1, 2'b00, 4'b1000, 2'b11, 0);
        drv1(1, 1, 2'b00, 4'b1000, 2'b11, 0);
        drv1(1, 1, 2'b00, 4'b1000, 2'b11, 0);
        drv1(1, 1, 2'b00, 4'b0001, 2'b00, 1);

        // Pause mid-period: held count resumes, step after 2 clocks
        drv1(1, 1, 2'b00, 4'b0001, 2'b00, 0);
        for (int i = 0; i < 5; i++) drv1(0, 1, 2'b00, 4'b0000, 2'b00, 0);
        drv1(1, 1, 2'b00, 4'b0001, 2'b00, 0);
        drv1(1, 1, 2'b00, 4'b0010, 2'b01, 0);

        // Scan to 10, manual override, back to scan with fresh period
        drv1(1, 1, 2'b00, 4'b0010, 2'b01, 0);
        drv1(1, 1, 2'b00, 4'b0010, 2'b01, 0);
        drv1(1, 1, 2'b00, 4'b0100, 2'b10, 0);
        drv1(1, 0, 2'b01, 4'b0010, 2'b01, 0);
        drv1(1, 1, 2'b01, 4'b0010, 2'b01, 0);
        drv1(1, 1, 2'b01, 4'b0010, 2'b01, 0);
        drv1(1, 1, 2'b01, 4'b0100, 2'b10, 0);
        drv1(1, 1, 2'b01, 4'b0100, 2'b10, 0);

        // Mid-scan async reset clears address and prescale count
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_d1",   16'(d1), 16'(pol4(4'b0000)));
        chk("midrst_sel1", 16'(s1), 16'd0);
        drv1(0, 1, 2'b00, 4'b0000, 2'b00, 0);
        drv1(1, 1, 2'b00, 4'b0001, 2'b00, 0);
        drv1(1, 1, 2'b00, 4'b0001, 2'b00, 0);
        drv1(1, 1, 2'b00, 4'b0010, 2'b01, 0);
        drv1(0, 0, 2'b00, 4'b0000, 2'b01, 0);

        // N=3, PRESCALE=1: steps every clock, wraps on the 8th
        drv2(1, 1, 3'd0, 8'b00000010, 3'd1, 0);
        drv2(1, 1, 3'd0, 8'b00000100, 3'd2, 0);
        drv2(1, 1, 3'd0, 8'b00001000, 3'd3, 0);
        drv2(1, 1, 3'd0, 8'b00010000, 3'd4, 0);
        drv2(1, 1, 3'd0, 8'b00100000, 3'd5, 0);
        drv2(1, 1, 3'd0, 8'b01000000, 3'd6, 0);
        drv2(1, 1, 3'd0, 8'b10000000, 3'd7, 0);
        drv2(1, 1, 3'd0, 8'b00000001, 3'd0, 1);
        drv2(1, 0, 3'd5, 8'b00100000, 3'd5, 0);
        drv2(0, 0, 3'd5, 8'b00000000, 3'd5, 0);

        repeat (3) @(negedge clk);
        chk("q1_drained", 16'(q1.size()), 16'd0);
        chk("q2_drained", 16'(q2.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
